// File: rtl/vs_spi_pkg.sv
// Shared types and constants for the VS1003B serial-bus arbiter.
// SCI opcodes/addresses, default word widths, FSM and grant encodings.
package vs_spi_pkg;

  localparam int CMD_W_DEF = 32;
  localparam int DAT_W_DEF = 16;

  localparam logic [7:0] SCI_WRITE = 8'h02;
  localparam logic [7:0] SCI_READ  = 8'h03;
  localparam logic [7:0] SCI_MODE  = 8'h00;
  localparam logic [7:0] SCI_VOL   = 8'h0B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_CTL,
    G_VOL,
    G_DAT
  } gnt_e;

endpackage

// File: rtl/vs_spi_shifter.sv
// MSB-first serializer: two clk_div cycles per bit (SCLK low, then high).
// done_o flags the high phase of the final bit.
module vs_spi_shifter
  import vs_spi_pkg::*;
#(
  parameter int W  = CMD_W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk_div,
  input  logic          RST,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [W-1:0]  word_i,
  input  logic [CW-1:0] cnt_i,
  output logic          sclk_o,
  output logic          si_o,
  output logic          done_o
);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (load_i) begin
      sr_d  = word_i;
      cnt_d = cnt_i;
      ph_d  = 1'b0;
    end else if (en_i) begin
      ph_d = ~ph_q;
      // Advance only after the rising half so SI holds across both phases.
      if (ph_q) begin
        sr_d  = {sr_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_div) begin
    if (!RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign sclk_o = en_i & ph_q;
  assign si_o   = en_i & sr_q[W-1];
  assign done_o = en_i & ph_q & (cnt_q == CW'(1));

endmodule

// File: rtl/vs_spi_arbiter.sv
// VS1003B bus arbiter: ctl/vol SCI commands and SDI data, gated on DREQ.
// Define VS_ARB_FAIR_EN to alternate command and data classes.
module vs_spi_arbiter
  import vs_spi_pkg::*;
#(
  parameter int CMD_W   = CMD_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int GAP_CYC = 2
) (
  input  logic             clk_div,
  input  logic             RST,
  input  logic             DREQ,
  input  logic             ctl_req,
  input  logic [CMD_W-1:0] ctl_cmd,
  output logic             ctl_ack,
  input  logic             vol_req,
  input  logic [CMD_W-1:0] vol_cmd,
  output logic             vol_ack,
  input  logic             dat_req,
  input  logic [DAT_W-1:0] dat_word,
  output logic             dat_ack,
  output logic             XCS,
  output logic             XDCS,
  output logic             SCLK,
  output logic             SI,
  output logic             busy
);

  localparam int CW = $clog2(CMD_W + 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);

  state_e         state_q, state_d;
  logic [7:0]     gap_q, gap_d;
  logic [2:0]     ack_q, ack_d;
  logic           cmd_q, cmd_d;
  logic           load;
  logic [CMD_W-1:0] word;
  logic [CW-1:0]  cnt;
  logic           any_cmd, pick_dat;
  logic           sel_ctl, sel_vol;
  logic           sh_en, sh_sclk, sh_si, sh_done;
  gnt_e           gnt;

  assign any_cmd = ctl_req | vol_req;

`ifdef VS_ARB_FAIR_EN
  logic last_cmd_q;

  always_ff @(posedge clk_div) begin
    if (!RST)
      last_cmd_q <= 1'b0;
    else if (load)
      last_cmd_q <= (gnt != G_DAT);
  end

  assign pick_dat = dat_req & (~any_cmd | last_cmd_q);
`else
  assign pick_dat = dat_req & ~any_cmd;
`endif

  assign sel_ctl = ctl_req & ~pick_dat;
  assign sel_vol = vol_req & ~ctl_req & ~pick_dat;

  always_comb begin
    gnt = G_NONE;
    unique case (1'b1)
      pick_dat: gnt = G_DAT;
      sel_ctl:  gnt = G_CTL;
      sel_vol:  gnt = G_VOL;
      default:  gnt = G_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cmd_d   = cmd_q;
    ack_d   = '0;
    load    = 1'b0;
    word    = ctl_cmd;
    cnt     = CW'(CMD_W);
    unique case (state_q)
      S_IDLE: begin
        if (DREQ && gnt != G_NONE) begin
          state_d = S_SHIFT;
          load    = 1'b1;
          cmd_d   = (gnt != G_DAT);
          unique case (gnt)
            G_CTL: ack_d = 3'b100;
            G_VOL: begin
              ack_d = 3'b010;
              word  = vol_cmd;
            end
            G_DAT: begin
              ack_d = 3'b001;
              word  = {dat_word, {(CMD_W-DAT_W){1'b0}}};
              cnt   = CW'(DAT_W);
            end
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        if (sh_done) begin
          state_d = S_GAP;
          gap_d   = GAP_LD;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0)
          state_d = S_IDLE;
        else
          gap_d = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_div) begin
    if (!RST) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      ack_q   <= '0;
      cmd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      cmd_q   <= cmd_d;
    end
  end

  assign sh_en = (state_q == S_SHIFT);

  vs_spi_shifter #(
    .W  (CMD_W),
    .CW (CW)
  ) u_shifter (
    .clk_div (clk_div),
    .RST     (RST),
    .en_i    (sh_en),
    .load_i  (load),
    .word_i  (word),
    .cnt_i   (cnt),
    .sclk_o  (sh_sclk),
    .si_o    (sh_si),
    .done_o  (sh_done)
  );

  assign XCS     = ~(sh_en & cmd_q);
  assign XDCS    = ~(sh_en & ~cmd_q);
  assign SCLK    = sh_sclk;
  assign SI      = sh_si;
  assign ctl_ack = ack_q[2];
  assign vol_ack = ack_q[1];
  assign dat_ack = ack_q[0];
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_vs_spi_arbiter.sv
// Directed bench for vs_spi_arbiter: reset abort, SCI/SDI framing,
// arbitration order (strict or VS_ARB_FAIR_EN) and DREQ gating.
module tb_vs_spi_arbiter;
  import vs_spi_pkg::*;

  localparam int GAP = 2;

  logic        clk_div = 1'b0;
  logic        RST = 1'b0;
  logic        DREQ = 1'b0;
  logic        ctl_req = 1'b0;
  logic        vol_req = 1'b0;
  logic        dat_req = 1'b0;
  logic [31:0] ctl_cmd = '0;
  logic [31:0] vol_cmd = '0;
  logic [15:0] dat_word = '0;
  logic        ctl_ack, vol_ack, dat_ack;
  logic        XCS, XDCS, SCLK, SI, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_div = ~clk_div;

  vs_spi_arbiter dut (
    .clk_div  (clk_div),
    .RST      (RST),
    .DREQ     (DREQ),
    .ctl_req  (ctl_req),
    .ctl_cmd  (ctl_cmd),
    .ctl_ack  (ctl_ack),
    .vol_req  (vol_req),
    .vol_cmd  (vol_cmd),
    .vol_ack  (vol_ack),
    .dat_req  (dat_req),
    .dat_word (dat_word),
    .dat_ack  (dat_ack),
    .XCS      (XCS),
    .XDCS     (XDCS),
    .SCLK     (SCLK),
    .SI       (SI),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  function automatic logic [2:0] acks();
    return {ctl_ack, vol_ack, dat_ack};
  endfunction

  function automatic logic [3:0] pins();
    return {XCS, XDCS, SCLK, SI};
  endfunction

  // Waits for a grant, then checks framing bit by bit and the gap.
  task automatic serve(input string tag, input logic [2:0] exp_ack,
                       input logic [31:0] exp_word, input int nb,
                       input bit is_cmd, input int drop_at);
    logic [2:0]  a;
    logic [31:0] rx;
    logic        si_lo;
    int          bad, bad_gap;
    a = '0;
    for (int i = 0; i < 200 && a == 3'b000; i++) begin
      tick();
      a = acks();
    end
    check({tag, ".ack"}, {29'b0, a}, {29'b0, exp_ack});
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    if (a[2]) ctl_req = 1'b0;
    if (a[1]) vol_req = 1'b0;
    if (a[0]) dat_req = 1'b0;
    rx = '0;
    bad = 0;
    for (int k = 0; k < nb; k++) begin
      if (k == drop_at) DREQ = 1'b0;
      if (SCLK !== 1'b0 || XCS !== !is_cmd || XDCS !== is_cmd || !busy)
        bad++;
      if (k > 0 && acks() != 3'b000) bad++;
      si_lo = SI;
      tick();
      if (SCLK !== 1'b1 || XCS !== !is_cmd || XDCS !== is_cmd)
        bad++;
      if (SI !== si_lo || acks() != 3'b000) bad++;
      rx = {rx[30:0], SI};
      tick();
    end
    check({tag, ".word"}, rx, exp_word);
    check({tag, ".pins"}, bad, 0);
    bad_gap = 0;
    for (int g = 0; g < GAP; g++) begin
      if (!busy || pins() !== 4'b1100) bad_gap++;
      tick();
    end
    check({tag, ".gap"}, bad_gap, 0);
    check({tag, ".idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int bad;

    repeat (3) tick();
    check("rst.pins", {28'b0, pins()}, 32'hC);
    check("rst.acks", {29'b0, acks()}, 32'h0);
    check("rst.busy", {31'b0, busy}, 32'h0);
    RST = 1'b1;
    tick();

    // Abort a command mid-word, then let it be reissued in full.
    DREQ = 1'b1;
    ctl_cmd = {SCI_WRITE, SCI_MODE, 16'h0804};
    ctl_req = 1'b1;
    tick();
    check("abort.ack", {29'b0, acks()}, 32'h4);
    check("abort.xcs", {31'b0, XCS}, 32'h0);
    repeat (9) tick();
    RST = 1'b0;
    tick();
    check("abort.pins", {28'b0, pins()}, 32'hC);
    check("abort.acks", {29'b0, acks()}, 32'h0);
    check("abort.busy", {31'b0, busy}, 32'h0);
    tick();
    check("abort.hold", {29'b0, acks()}, 32'h0);
    RST = 1'b1;
    serve("ctl", 3'b100, 32'h02000804, 32, 1'b1, -1);

    vol_cmd = {SCI_WRITE, SCI_VOL, 16'h2020};
    vol_req = 1'b1;
    serve("vol", 3'b010, 32'h020B2020, 32, 1'b1, -1);

    dat_word = 16'hA55A;
    dat_req = 1'b1;
    serve("dat", 3'b001, 32'h0000A55A, 16, 1'b0, -1);

    ctl_cmd = {SCI_WRITE, SCI_MODE, 16'h0800};
    vol_cmd = 32'h020B4040;
    dat_word = 16'h0F0F;
    ctl_req = 1'b1;
    vol_req = 1'b1;
    dat_req = 1'b1;
    serve("arb1", 3'b100, 32'h02000800, 32, 1'b1, -1);
`ifdef VS_ARB_FAIR_EN
    serve("arb2", 3'b001, 32'h00000F0F, 16, 1'b0, -1);
    serve("arb3", 3'b010, 32'h020B4040, 32, 1'b1, -1);
`else
    serve("arb2", 3'b010, 32'h020B4040, 32, 1'b1, -1);
    serve("arb3", 3'b001, 32'h00000F0F, 16, 1'b0, -1);
`endif

    // DREQ low blocks all grants.
    DREQ = 1'b0;
    ctl_req = 1'b1;
    dat_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acks() != 3'b000 || busy || pins() !== 4'b1100) bad++;
    end
    check("dreq0.block", bad, 0);

    // DREQ falls mid-word: word completes, next grant waits.
    ctl_req = 1'b0;
    dat_word = 16'hC3C3;
    DREQ = 1'b1;
    serve("drop", 3'b001, 32'h0000C3C3, 16, 1'b0, 5);
    dat_word = 16'h1234;
    dat_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acks() != 3'b000 || busy) bad++;
    end
    check("drop.wait", bad, 0);
    DREQ = 1'b1;
    serve("dat2", 3'b001, 32'h00001234, 16, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
